// File: rtl/mem_launch_pkg.sv
// Shared types and constants for the kernel launch controller and its
// saturating cycle counter.
package mem_launch_pkg;

    localparam int CNT_W      = 16;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_KRST   = 3'd1,
        ST_RUN    = 3'd2,
        ST_READ   = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/mem_load_launch_if.sv
// Preload stream, RAM debug port and result handshake seen by the launch
// controller; master is the controller side, slave the host/RAM side.
interface mem_load_launch_if
    import mem_launch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    logic [ADDR_W-1:0] dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;
    logic              dbg_wr_en;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [CNT_W-1:0]  res_cycles;
    logic              res_timeout;

    modport master (
        input  ld_valid, ld_addr, ld_data, ld_last, dbg_data, res_ready,
        output ld_ready, dbg_wr_addr, dbg_wr_data, dbg_wr_en, dbg_addr,
               res_valid, res_data, res_cycles, res_timeout
    );

    modport slave (
        output ld_valid, ld_addr, ld_data, ld_last, dbg_data, res_ready,
        input  ld_ready, dbg_wr_addr, dbg_wr_data, dbg_wr_en, dbg_addr,
               res_valid, res_data, res_cycles, res_timeout
    );

endinterface

// File: rtl/mem_load_launch_sat_counter.sv
// Clearable 16-bit up-counter that saturates at all-ones; times both the
// kernel reset hold and the kernel run.
module sat_counter
    import mem_launch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register; clear takes priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= sat_inc(count_r);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/mem_load_launch.sv
// Launch controller: preloads the shared RAM with the kernel held in reset,
// runs the kernel until done or timeout, then returns one result word.
module mem_load_launch
    import mem_launch_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RESULT_ADDR = 3,
    parameter int KRST_CYCLES = 2,
    parameter int READ_LAT    = 1,
    parameter int MAX_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    mem_load_launch_if.master bus,
    output logic              kern_rst,
    input  logic              kern_valid
);

    localparam logic [CNT_W-1:0]  KRST_LAST = CNT_W'(KRST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(READ_LAT);
    localparam logic [ADDR_W-1:0] RES_ADDR  = ADDR_W'(RESULT_ADDR);

    state_e state_r, state_nxt;

    logic [CNT_W-1:0] cnt_s;
    logic             cnt_clr_s, cnt_en_s;
    logic [CNT_W-1:0] rd_cnt_r, rd_cnt_nxt;
    logic [CNT_W-1:0] run_inc_s;
    logic             beat_s, last_beat_s, krst_done_s, run_done_s, read_done_s;

    logic              ld_ready_r,    ld_ready_nxt;
    logic              kern_rst_r,    kern_rst_nxt;
    logic              dbg_wr_en_r,   dbg_wr_en_nxt;
    logic [ADDR_W-1:0] dbg_wr_addr_r, dbg_wr_addr_nxt;
    logic [DATA_W-1:0] dbg_wr_data_r, dbg_wr_data_nxt;
    logic [ADDR_W-1:0] dbg_addr_r,    dbg_addr_nxt;
    logic              res_valid_r,   res_valid_nxt;
    logic [DATA_W-1:0] res_data_r,    res_data_nxt;
    logic [CNT_W-1:0]  res_cycles_r,  res_cycles_nxt;
    logic              res_timeout_r, res_timeout_nxt;

    // The counter holds the number of completed KRST or RUN cycles; after
    // the RUN exit edge it already includes the final run cycle.
    sat_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .count (cnt_s)
    );

    assign beat_s      = (state_r == ST_LOAD) && bus.ld_valid && ld_ready_r;
    assign last_beat_s = beat_s && bus.ld_last;
    assign krst_done_s = (state_r == ST_KRST) && (cnt_s == KRST_LAST);
    assign run_inc_s   = sat_inc(cnt_s);
    assign run_done_s  = (state_r == ST_RUN) && (kern_valid || (run_inc_s >= MAX_CNT));
    assign read_done_s = (state_r == ST_READ) && (rd_cnt_r == RD_LAST);
    assign cnt_clr_s   = last_beat_s || krst_done_s;
    assign cnt_en_s    = (state_r == ST_KRST) || (state_r == ST_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_LOAD: begin
                if (last_beat_s) state_nxt = ST_KRST;
                else             state_nxt = ST_LOAD;
            end
            ST_KRST: begin
                if (krst_done_s) state_nxt = ST_RUN;
                else             state_nxt = ST_KRST;
            end
            ST_RUN: begin
                if (run_done_s) state_nxt = ST_READ;
                else            state_nxt = ST_RUN;
            end
            ST_READ: begin
                if (read_done_s) state_nxt = ST_RESULT;
                else             state_nxt = ST_READ;
            end
            ST_RESULT: begin
                if (bus.res_ready) state_nxt = ST_LOAD;
                else               state_nxt = ST_RESULT;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        ld_ready_nxt    = ld_ready_r;
        kern_rst_nxt    = kern_rst_r;
        dbg_wr_en_nxt   = 1'b0;
        dbg_wr_addr_nxt = dbg_wr_addr_r;
        dbg_wr_data_nxt = dbg_wr_data_r;
        dbg_addr_nxt    = dbg_addr_r;
        res_valid_nxt   = res_valid_r;
        res_data_nxt    = res_data_r;
        res_cycles_nxt  = res_cycles_r;
        res_timeout_nxt = res_timeout_r;
        case (state_r)
            ST_LOAD: begin
                kern_rst_nxt = 1'b1;
                if (beat_s) begin
                    dbg_wr_en_nxt   = 1'b1;
                    dbg_wr_addr_nxt = bus.ld_addr;
                    dbg_wr_data_nxt = bus.ld_data;
                    ld_ready_nxt    = ~bus.ld_last;
                end else begin
                    ld_ready_nxt = 1'b1;
                end
            end
            ST_KRST: begin
                ld_ready_nxt = 1'b0;
                kern_rst_nxt = ~krst_done_s;
            end
            ST_RUN: begin
                // A done flag on the timeout cycle still counts as success.
                if (run_done_s) begin
                    kern_rst_nxt    = 1'b1;
                    dbg_addr_nxt    = RES_ADDR;
                    res_timeout_nxt = ~kern_valid;
                end else begin
                    kern_rst_nxt = 1'b0;
                end
            end
            ST_READ: begin
                kern_rst_nxt = 1'b1;
                if (read_done_s) begin
                    res_valid_nxt  = 1'b1;
                    res_data_nxt   = bus.dbg_data;
                    res_cycles_nxt = cnt_s;
                end else begin
                    res_valid_nxt = 1'b0;
                end
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    res_valid_nxt = 1'b0;
                    ld_ready_nxt  = 1'b1;
                end else begin
                    res_valid_nxt = 1'b1;
                    ld_ready_nxt  = 1'b0;
                end
            end
            default: begin
                ld_ready_nxt  = 1'b1;
                kern_rst_nxt  = 1'b1;
                res_valid_nxt = 1'b0;
            end
        endcase
    end

    // Read-latency counter, zero whenever READ is not active.
    always_comb begin
        if (state_r == ST_READ) begin
            rd_cnt_nxt = sat_inc(rd_cnt_r);
        end else begin
            rd_cnt_nxt = {CNT_W{1'b0}};
        end
    end

    // Read-latency counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_r <= {CNT_W{1'b0}};
        end else begin
            rd_cnt_r <= rd_cnt_nxt;
        end
    end

    // Output registers; reset drops any in-flight debug write at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_ready_r    <= 1'b1;
            kern_rst_r    <= 1'b1;
            dbg_wr_en_r   <= 1'b0;
            dbg_wr_addr_r <= {ADDR_W{1'b0}};
            dbg_wr_data_r <= {DATA_W{1'b0}};
            dbg_addr_r    <= {ADDR_W{1'b0}};
            res_valid_r   <= 1'b0;
            res_data_r    <= {DATA_W{1'b0}};
            res_cycles_r  <= {CNT_W{1'b0}};
            res_timeout_r <= 1'b0;
        end else begin
            ld_ready_r    <= ld_ready_nxt;
            kern_rst_r    <= kern_rst_nxt;
            dbg_wr_en_r   <= dbg_wr_en_nxt;
            dbg_wr_addr_r <= dbg_wr_addr_nxt;
            dbg_wr_data_r <= dbg_wr_data_nxt;
            dbg_addr_r    <= dbg_addr_nxt;
            res_valid_r   <= res_valid_nxt;
            res_data_r    <= res_data_nxt;
            res_cycles_r  <= res_cycles_nxt;
            res_timeout_r <= res_timeout_nxt;
        end
    end

    assign bus.ld_ready    = ld_ready_r;
    assign bus.dbg_wr_en   = dbg_wr_en_r;
    assign bus.dbg_wr_addr = dbg_wr_addr_r;
    assign bus.dbg_wr_data = dbg_wr_data_r;
    assign bus.dbg_addr    = dbg_addr_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_data    = res_data_r;
    assign bus.res_cycles  = res_cycles_r;
    assign bus.res_timeout = res_timeout_r;
    assign kern_rst        = kern_rst_r;

endmodule

// File: tb/tb_mem_load_launch.sv
// Bench for mem_load_launch: RAM and kernel stubs, randomized jobs, and a
// scoreboard of expected results checked by a free-running monitor.
module tb_mem_load_launch;
    import mem_launch_pkg::*;

    localparam int AW = 5, DW = 32, RA = 3, KRST = 2, RLAT = 1, MAXC = 16;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } beat_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;
    typedef struct { logic [DW-1:0] data; logic [15:0] cyc; logic to; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic kern_rst, kern_valid, kern_we;

    mem_load_launch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_load_launch #(
        .ADDR_W(AW), .DATA_W(DW), .RESULT_ADDR(RA),
        .KRST_CYCLES(KRST), .READ_LAT(RLAT), .MAX_CYCLES(MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .kern_rst   (kern_rst),
        .kern_valid (kern_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, cyc = 0;
    logic [DW-1:0] ram [32];
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] rd_q = 32'd0;
    int            k_target = 0;
    bit            k_wr = 1'b0;
    logic [DW-1:0] k_val = 32'd0;
    logic [7:0]    k_cnt = 8'd0;

    beat_t beats_q [$];
    wr_t   wr_q [$];
    exp_t  exp_q [$];
    wr_t   w_m;
    exp_t  e_m;
    int    last_cyc = 0, run_last = 0;
    bit    pend_run = 1'b0, prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Kernel stub: counts cycles out of reset, optionally writes RAM[3] in
    // its third run cycle, raises done in run cycle k_target (0 = never).
    always @(posedge clk) begin
        if (kern_rst) k_cnt <= 8'd0;
        else          k_cnt <= k_cnt + 8'd1;
    end
    assign kern_valid = !kern_rst && (k_target != 0) && (int'(k_cnt) == k_target - 1);
    assign kern_we    = !kern_rst && k_wr && (k_cnt == 8'd2);

    // Shared RAM with one-cycle registered debug read.
    always @(posedge clk) begin
        if (bus.dbg_wr_en) ram[bus.dbg_wr_addr] <= bus.dbg_wr_data;
        if (kern_we)       ram[RA] <= k_val;
        rd_q <= ram[bus.dbg_addr];
    end
    assign bus.dbg_data = rd_q;

    // Monitor: write-port traffic, launch/complete latencies, result scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.dbg_wr_en) begin
                check("wr_while_krst", kern_rst, 1);
                check("wr_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    w_m = wr_q.pop_front();
                    check("wr_addr", bus.dbg_wr_addr, w_m.a);
                    check("wr_data", bus.dbg_wr_data, w_m.d);
                    check("wr_lat", cyc - w_m.c, 1);
                end
            end
            if (bus.ld_valid && bus.ld_ready) begin
                wr_q.push_back('{a: bus.ld_addr, d: bus.ld_data, c: cyc});
                if (bus.ld_last) begin
                    last_cyc = cyc;
                    pend_run = 1'b1;
                end
            end
            if (!kern_rst) begin
                if (pend_run) begin
                    check("run_start", cyc, last_cyc + KRST + 1);
                    pend_run = 1'b0;
                end
                run_last = cyc;
            end
            if (bus.res_valid && !prev_valid) check("res_lat", cyc, run_last + RLAT + 2);
            if (bus.res_valid && bus.res_ready) begin
                check("res_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_m = exp_q.pop_front();
                    check("res_data", bus.res_data, e_m.data);
                    check("res_cycles", bus.res_cycles, e_m.cyc);
                    check("res_timeout", bus.res_timeout, e_m.to);
                end
            end
            prev_valid = bus.res_valid;
        end else begin
            prev_valid = 1'b0;
            pend_run   = 1'b0;
            wr_q.delete();
        end
    end

    task automatic add_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
        beat_t b;
        b.a = a;
        b.d = d;
        beats_q.push_back(b);
    endtask

    task automatic load_all();
        bit ok;
        foreach (beats_q[i]) begin
            ok = 1'b0;
            bus.ld_valid = 1'b1;
            bus.ld_addr  = beats_q[i].a;
            bus.ld_data  = beats_q[i].d;
            bus.ld_last  = (i == beats_q.size() - 1);
            for (int j = 0; j < 50; j++) begin
                @(negedge clk);
                if (bus.ld_ready) begin ok = 1'b1; break; end
            end
            if (!ok) check("ld_ready_wait", bus.ld_ready, 1);
            @(posedge clk); #1;
            bus.ld_valid = 1'b0;
            bus.ld_last  = 1'b0;
            if (i < beats_q.size() - 1) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
    endtask

    // Reference: RAM image after the load, optional kernel write, then the
    // run length and timeout from the done cycle versus the cycle limit.
    task automatic run_job(input int target, input bit kwr, input logic [DW-1:0] kval,
                           input int hold, input bit early);
        int run_len;
        bit to, ok;
        exp_t e;
        k_target = target;
        k_wr     = kwr;
        k_val    = kval;
        foreach (beats_q[i]) ref_mem[beats_q[i].a] = beats_q[i].d;
        to      = !(target != 0 && target <= MAXC);
        run_len = to ? MAXC : target;
        if (kwr && run_len >= 3) ref_mem[RA] = kval;
        e.data = ref_mem[RA];
        e.cyc  = 16'(run_len);
        e.to   = to;
        exp_q.push_back(e);
        load_all();
        if (early) bus.res_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin ok = 1'b1; break; end
        end
        if (ok) begin
            if (early) begin
                @(posedge clk); #1;
                bus.res_ready = 1'b0;
            end else begin
                bus.ld_valid = 1'b1;
                bus.ld_addr  = AW'($urandom_range(0, 31));
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    check("hold_valid", bus.res_valid, 1);
                    check("hold_data", bus.res_data, e.data);
                    check("hold_cycles", bus.res_cycles, e.cyc);
                    check("hold_timeout", bus.res_timeout, e.to);
                    check("hold_ld_ready", bus.ld_ready, 0);
                end
                @(posedge clk); #1;
                bus.ld_valid  = 1'b0;
                bus.res_ready = 1'b1;
                @(posedge clk); #1;
                bus.res_ready = 1'b0;
            end
            @(negedge clk);
            check("res_valid_drop", bus.res_valid, 0);
            check("ld_ready_back", bus.ld_ready, 1);
        end else begin
            check("res_valid_wait", bus.res_valid, 1);
            bus.res_ready = 1'b0;
            void'(exp_q.pop_back());
        end
        beats_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        int nb;
        bit ok;
        bus.ld_valid = 1'b0; bus.ld_addr = 5'd0; bus.ld_data = 32'd0;
        bus.ld_last = 1'b0;  bus.res_ready = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ld_ready", bus.ld_ready, 1);
        check("rst_kern_rst", kern_rst, 1);
        check("rst_wr_en", bus.dbg_wr_en, 0);
        check("rst_wr_addr", bus.dbg_wr_addr, 0);
        check("rst_wr_data", bus.dbg_wr_data, 0);
        check("rst_dbg_addr", bus.dbg_addr, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_cycles", bus.res_cycles, 0);
        check("rst_res_timeout", bus.res_timeout, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Basic load and run, result held for five cycles.
        add_beat(5'd4, 32'd3);
        add_beat(5'd3, 32'd23);
        run_job(6, 1'b0, 32'd0, 5, 1'b0);
        check("ram4", ram[4], 32'd3);

        // Kernel overwrites the result word; ready already high.
        add_beat(5'd10, 32'h1234);
        add_beat(5'd3, 32'h77);
        run_job(8, 1'b1, 32'h55, 0, 1'b1);

        // Kernel never finishes.
        add_beat(5'd7, $urandom);
        run_job(0, 1'b0, 32'd0, 2, 1'b0);

        // Done on exactly the limit cycle.
        add_beat(5'd3, 32'hABCD);
        run_job(MAXC, 1'b0, 32'd0, 1, 1'b1);

        // Reset in the third run cycle.
        add_beat(5'd3, 32'hBEEF);
        add_beat(5'd9, 32'h99);
        k_target = 0;
        k_wr     = 1'b0;
        foreach (beats_q[i]) ref_mem[beats_q[i].a] = beats_q[i].d;
        load_all();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!kern_rst) begin ok = 1'b1; break; end
        end
        check("abort_in_run", kern_rst, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_kern_rst", kern_rst, 1);
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_ld_ready", bus.ld_ready, 1);
        check("abort_wr_en", bus.dbg_wr_en, 0);
        beats_q.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int j = 0; j < 10; j++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) add_beat(AW'($urandom_range(0, 31)), $urandom);
            run_job($urandom_range(0, 20), 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        check("exp_drained", exp_q.size(), 0);
        check("wr_drained", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_load_launch.md
# mem_load_launch

Host-side launch controller for an HLS-generated kernel that shares a `RAM2` memory. It streams preload words into the RAM through the debug write port while holding the kernel in reset, then releases the kernel and counts cycles until `valid`. On completion it reads one result word back through the debug read port and presents it, with cycle count and timeout flag, on a valid/ready result interface. It sits directly upstream of the kernel/RAM pair and replaces hand-written testbench sequencing.

## Interface
Parameters:
- `ADDR_W`, 5: RAM address width.
- `DATA_W`, 32: RAM data width.
- `RESULT_ADDR`, 3: RAM word read back after completion.
- `KRST_CYCLES`, 2: cycles `kern_rst` is held after load; minimum 1.
- `READ_LAT`, 1: cycles from `dbg_addr` stable to `dbg_data` valid.
- `MAX_CYCLES`, 1024: run-cycle limit before timeout; must fit in 16 bits.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `ld_valid`, in, 1: preload beat valid.
- `ld_ready`, out, 1: preload beat accepted.
- `ld_addr`, in, `ADDR_W`: preload address.
- `ld_data`, in, `DATA_W`: preload data.
- `ld_last`, in, 1: final preload beat.
- `dbg_wr_addr`, out, `ADDR_W`: RAM debug write address.
- `dbg_wr_data`, out, `DATA_W`: RAM debug write data.
- `dbg_wr_en`, out, 1: RAM debug write enable.
- `dbg_addr`, out, `ADDR_W`: RAM debug read address.
- `dbg_data`, in, `DATA_W`: RAM debug read data.
- `kern_rst`, out, 1: kernel reset; active-high and synchronous on the kernel side.
- `kern_valid`, in, 1: kernel done.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: result consumed.
- `res_data`, out, `DATA_W`: word read from `RESULT_ADDR`.
- `res_cycles`, out, 16: count of RUN cycles.
- `res_timeout`, out, 1: run hit `MAX_CYCLES`.

## Operation
- FSM states: LOAD, KRST, RUN, READ, RESULT. Reset state is LOAD.
- All outputs are registered. Values while `rst`=0:
  - `ld_ready`=1, `kern_rst`=1.
  - `dbg_wr_en`=0, `dbg_wr_addr`=0, `dbg_wr_data`=0, `dbg_addr`=0.
  - `res_valid`=0, `res_data`=0, `res_cycles`=0, `res_timeout`=0.
- LOAD:
  - `ld_ready`=1, `kern_rst`=1.
  - Each accepted beat (`ld_valid`&`ld_ready`) drives `dbg_wr_addr`/`dbg_wr_data` with `dbg_wr_en`=1 on the next cycle only. Back-to-back beats give one write per cycle.
  - Beat with `ld_last`=1: write it, drop `ld_ready` next cycle, go to KRST. Repeated addresses: last write wins.
- KRST: `kern_rst`=1 for exactly `KRST_CYCLES` cycles, then RUN. The cycle counter is cleared to 0 on entry.
- RUN:
  - `kern_rst`=0; the counter increments every RUN cycle and saturates at 0xFFFF.
  - `kern_valid`=1 sampled: go to READ, `res_timeout`=0.
  - Counter reaching `MAX_CYCLES`: go to READ, `res_timeout`=1.
  - If both happen on the same cycle, `kern_valid` wins and `res_timeout`=0.
- READ:
  - `kern_rst`=1 again; `dbg_addr`=`RESULT_ADDR`.
  - Stays `READ_LAT`+1 cycles. On the last cycle it samples `dbg_data` into `res_data` and latches `res_cycles`.
- RESULT:
  - `res_valid`=1; `res_data`, `res_cycles` and `res_timeout` are held stable until `res_ready`.
  - On handshake: `res_valid`=0 next cycle, return to LOAD, `ld_ready`=1.
  - `res_ready` high on the first RESULT cycle completes in one cycle.
- `ld_valid` outside LOAD is ignored; no beat is lost because `ld_ready`=0.
- Reset mid-operation: the FSM returns to LOAD immediately, and any in-flight debug write is dropped (`dbg_wr_en`=0 asynchronously). RAM contents are not cleared.

## Timing
- Load: last accepted beat at cycle t → last `dbg_wr_en` at t+1 → KRST occupies t+1 … t+KRST_CYCLES → first RUN cycle at t+KRST_CYCLES+1.
- Completion: `kern_valid` sampled at cycle r → `res_valid` at r+READ_LAT+2.
- `res_cycles` equals the number of RUN cycles up to and including the one where `kern_valid` was sampled.
- `dbg_wr_en` and `kern_rst` deasserted are never both true in the same cycle; the RAM is never written by both masters at once.

## Structure
- Package `mem_launch_pkg` holds:
  - the state enum (`ST_LOAD`, `ST_KRST`, `ST_RUN`, `ST_READ`, `ST_RESULT`);
  - the 16-bit counter width constant;
  - default `ADDR_W`/`DATA_W`.
- One sub-module, `sat_counter`: clear, enable, 16-bit saturating. Shared by the KRST and RUN counts.
- FSM and datapath live in `mem_load_launch`.

## Test plan
- Load {4:3}, {3:23, last}; stub kernel asserts valid 6 cycles after reset release → RAM[4]=3; `res_data`=23, `res_cycles`=6, `res_timeout`=0.
- Stub kernel writes 0x55 to addr 3 before valid → `res_data`=0x55.
- Kernel never asserts valid, `MAX_CYCLES`=16 → `res_valid` with `res_timeout`=1, `res_cycles`=16.
- Hold `res_ready`=0 for 5 cycles → result fields stable, `ld_ready`=0; on release, `ld_ready`=1 the next cycle.
- Drop `rst` during RUN at cycle 3 → `kern_rst`=1, `res_valid`=0, `ld_ready`=1; a fresh load runs normally.
- `kern_valid` and counter = `MAX_CYCLES` on the same cycle → `res_timeout`=0.
